// File: rtl/bpm_test_link_pkg.sv
// Shared constants for the BPM test-pattern link checker:
// magic words, header field positions, status codes and receiver states.
package bpm_test_link_pkg;

  localparam logic [15:0] MAGIC_HDR = 16'hA5BE;
  localparam logic [15:0] MAGIC_X   = 16'hCAFE;
  localparam logic [15:0] MAGIC_Y   = 16'hBEEF;

  localparam int HDR_VALID_BIT = 15;
  localparam int HDR_CELL_LSB  = 10;
  localparam int HDR_RSVD_BIT  = 9;
  localparam int HDR_BPM_LSB   = 5;
  localparam int HDR_IDX_LSB   = 0;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_FRAMING = 2'd1;
  localparam logic [1:0] ST_CONTENT = 2'd2;
  localparam logic [1:0] ST_SHORT   = 2'd3;

  typedef enum logic [2:0] {
    RX_HEADER = 3'd0,
    RX_X      = 3'd1,
    RX_Y      = 3'd2,
    RX_S      = 3'd3,
    RX_RESYNC = 3'd4
  } rx_state_t;

  // Framing errors take priority over content errors.
  function automatic logic [1:0] session_code(
    input logic frm,
    input logic cnt
  );
    if (frm) return ST_FRAMING;
    if (cnt) return ST_CONTENT;
    return ST_OK;
  endfunction

endpackage

// File: rtl/read_bpm_test_link_sat_counter.sv
// Saturating up-counter with a fixed step.
// Holds at all-ones once the next step would overflow.
module sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  localparam logic [WIDTH-1:0] LP_MAX  = '1;
  localparam logic [WIDTH-1:0] LP_STEP = WIDTH'(STEP);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_room;

  assign w_room  = LP_MAX - r_count;
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= (w_room < LP_STEP) ? LP_MAX : r_count + LP_STEP;
    end
  end

endmodule

// File: rtl/read_bpm_test_link.sv
// Checks the BPM test-pattern stream packet by packet, reporting per FA session.
// Define BPM_TEST_FACYCLE_CHECK_EN to also verify the FA cycle field S[30:16].
module read_bpm_test_link
  import bpm_test_link_pkg::*;
#(
  parameter int BPM_GLOBAL_INDEX    = 2,
  parameter int EXPECTED_BPM_COUNT  = 16,
  parameter int EXPECTED_CELL_INDEX = 12
) (
  input  logic        auroraUserClk,
  input  logic        auroraUserRst_n,
  input  logic        auroraFAstrobe,
  input  logic [31:0] BPM_TEST_AXI_STREAM_RX_tdata,
  input  logic        BPM_TEST_AXI_STREAM_RX_tvalid,
  input  logic        BPM_TEST_AXI_STREAM_RX_tlast,
  output logic        BPM_TEST_AXI_STREAM_RX_tready,
  output logic        TESTstatusStrobe,
  output logic [1:0]  TESTstatusCode,
  output logic [31:0] goodPacketCount,
  output logic [15:0] errorCount,
  output logic [14:0] lastFAcycle,
  output logic [2:0]  dbgRxState
);
  localparam logic [4:0] LP_CELL = 5'(EXPECTED_CELL_INDEX);
  localparam logic [3:0] LP_BPM  = 4'(BPM_GLOBAL_INDEX);
  localparam logic [4:0] LP_LAST = 5'(EXPECTED_BPM_COUNT - 1);

  rx_state_t   r_state, w_rx_nxt, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic        r_done, r_pkt_bad, r_sess_frm, r_sess_cnt;
  logic        r_strobe;
  logic [1:0]  r_code;
  logic [31:0] r_good;
  logic [14:0] r_fa_last;

  logic [31:0] w_d;
  logic        w_acc, w_last, w_fa;
  logic        w_hdr_ok, w_x_ok, w_y_ok, w_s_ok, w_fa_ok;
  logic        w_beat_bad, w_frm, w_pkt_end, w_bad_now;
  logic        w_count, w_final, w_short, w_err_inc;

  assign w_d    = BPM_TEST_AXI_STREAM_RX_tdata;
  assign w_last = BPM_TEST_AXI_STREAM_RX_tlast;
  assign w_fa   = auroraFAstrobe;

  assign BPM_TEST_AXI_STREAM_RX_tready = auroraUserRst_n;
  assign w_acc = BPM_TEST_AXI_STREAM_RX_tvalid
               & BPM_TEST_AXI_STREAM_RX_tready;

  assign w_hdr_ok = (w_d[31:16] == MAGIC_HDR)
                 && w_d[HDR_VALID_BIT]
                 && (w_d[HDR_CELL_LSB +: 5] == LP_CELL)
                 && !w_d[HDR_RSVD_BIT]
                 && (w_d[HDR_BPM_LSB +: 4] == LP_BPM)
                 && (w_d[HDR_IDX_LSB +: 5] == r_idx);
  assign w_x_ok = (w_d == {MAGIC_X, 11'd0, r_idx});
  assign w_y_ok = (w_d == {MAGIC_Y, 11'd0, r_idx});
  assign w_s_ok = !w_d[31]
               && (w_d[10:5] == 6'd0)
               && (w_d[4:0] == r_idx)
               && w_fa_ok;

`ifdef BPM_TEST_FACYCLE_CHECK_EN
  logic [14:0] r_fa_sess, r_fa_prev;
  logic        r_fa_have, r_fa_prev_vld;
  logic        w_s_take;

  assign w_s_take = w_acc && (r_state == RX_S) && !r_done;
  assign w_fa_ok  = r_fa_have
                  ? (w_d[30:16] == r_fa_sess)
                  : (!r_fa_prev_vld
                     || (w_d[30:16] == r_fa_prev + 15'd1));

  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      r_fa_sess     <= '0;
      r_fa_prev     <= '0;
      r_fa_have     <= 1'b0;
      r_fa_prev_vld <= 1'b0;
    end else begin
      if (w_s_take) begin
        r_fa_sess <= w_d[30:16];
        r_fa_have <= 1'b1;
      end
      // A beat arriving with the strobe still belongs to the old session.
      if (w_fa) begin
        r_fa_have <= 1'b0;
        if (r_fa_have || w_s_take) begin
          r_fa_prev     <= w_s_take ? w_d[30:16] : r_fa_sess;
          r_fa_prev_vld <= 1'b1;
        end
      end
    end
  end
`else
  assign w_fa_ok = 1'b1;
`endif

  always_comb begin
    w_rx_nxt   = r_state;
    w_beat_bad = 1'b0;
    w_frm      = 1'b0;
    w_pkt_end  = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        RX_HEADER: begin
          w_beat_bad = !w_hdr_ok;
          w_frm      = w_last;
          w_rx_nxt   = w_last ? RX_HEADER : RX_X;
        end
        RX_X: begin
          w_beat_bad = !w_x_ok;
          w_frm      = w_last;
          w_rx_nxt   = w_last ? RX_HEADER : RX_Y;
        end
        RX_Y: begin
          w_beat_bad = !w_y_ok;
          w_frm      = w_last;
          w_rx_nxt   = w_last ? RX_HEADER : RX_S;
        end
        RX_S: begin
          w_beat_bad = !w_s_ok;
          w_pkt_end  = w_last;
          w_frm      = !w_last;
          w_rx_nxt   = w_last ? RX_HEADER : RX_RESYNC;
        end
        RX_RESYNC: begin
          w_rx_nxt = w_last ? RX_HEADER : RX_RESYNC;
        end
        default: w_rx_nxt = RX_HEADER;
      endcase
    end
    w_state_nxt = w_fa ? RX_HEADER : w_rx_nxt;
  end

  assign w_bad_now = r_pkt_bad | w_beat_bad;
  assign w_count   = w_pkt_end & !r_done;
  assign w_final   = w_count & (r_idx == LP_LAST);
  assign w_idx_nxt = r_idx + {4'd0, w_count};
  assign w_short   = w_fa & !r_done & !w_final
                   & (w_idx_nxt != 5'd0);
  // Surplus packets after a finished session are errors too.
  assign w_err_inc = w_frm
                   | (w_pkt_end & (r_done | w_bad_now));

  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      r_state <= RX_HEADER;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_pkt_bad  <= 1'b0;
      r_sess_frm <= 1'b0;
      r_sess_cnt <= 1'b0;
      r_strobe   <= 1'b0;
      r_code     <= ST_OK;
      r_good     <= '0;
      r_fa_last  <= '0;
    end else begin
      r_strobe <= w_final | w_short;
      if (w_final) begin
        r_code <= session_code(r_sess_frm,
                               r_sess_cnt | w_bad_now);
      end else if (w_short) begin
        r_code <= ST_SHORT;
      end
      if (w_count && !w_bad_now) begin
        r_good <= r_good + 32'd1;
      end
      if (w_acc && (r_state == RX_S)) begin
        r_fa_last <= w_d[30:16];
      end
      if (w_fa) begin
        r_idx      <= '0;
        r_done     <= 1'b0;
        r_pkt_bad  <= 1'b0;
        r_sess_frm <= 1'b0;
        r_sess_cnt <= 1'b0;
      end else begin
        r_idx      <= w_idx_nxt;
        r_done     <= r_done | w_final;
        r_sess_frm <= r_sess_frm | w_frm;
        r_sess_cnt <= r_sess_cnt | (w_count & w_bad_now);
        if (w_acc) begin
          r_pkt_bad <= w_bad_now
                    && (w_rx_nxt inside {RX_X, RX_Y, RX_S});
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (16),
    .STEP  (1)
  ) u_err_cnt (
    .i_clk   (auroraUserClk),
    .i_rst_n (auroraUserRst_n),
    .i_inc   (w_err_inc),
    .o_count (errorCount)
  );

  assign TESTstatusStrobe = r_strobe;
  assign TESTstatusCode   = r_code;
  assign goodPacketCount  = r_good;
  assign lastFAcycle      = r_fa_last;
  assign dbgRxState       = r_state;

endmodule

// File: tb/tb_read_bpm_test_link.sv
// Directed scoreboard bench for read_bpm_test_link.
// Build with BPM_TEST_FACYCLE_CHECK_EN to exercise the FA cycle check.
module tb_read_bpm_test_link;
  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        fa     = 1'b0;
  logic        tvalid = 1'b0;
  logic        tlast  = 1'b0;
  logic [31:0] tdata  = '0;
  logic        tready, strobe;
  logic [1:0]  code;
  logic [31:0] good;
  logic [15:0] err;
  logic [14:0] falast;
  logic [2:0]  dbg;

  int cyc    = 0;
  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } exp_t;
  exp_t sb[$];

`ifdef BPM_TEST_FACYCLE_CHECK_EN
  localparam logic [1:0] FA_CODE = 2'd2;
  localparam int FA_GOOD = 31;
  localparam int FA_ERR  = 1;
`else
  localparam logic [1:0] FA_CODE = 2'd0;
  localparam int FA_GOOD = 32;
  localparam int FA_ERR  = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  read_bpm_test_link dut (
    .auroraUserClk                 (clk),
    .auroraUserRst_n               (rst_n),
    .auroraFAstrobe                (fa),
    .BPM_TEST_AXI_STREAM_RX_tdata  (tdata),
    .BPM_TEST_AXI_STREAM_RX_tvalid (tvalid),
    .BPM_TEST_AXI_STREAM_RX_tlast  (tlast),
    .BPM_TEST_AXI_STREAM_RX_tready (tready),
    .TESTstatusStrobe              (strobe),
    .TESTstatusCode                (code),
    .goodPacketCount               (good),
    .errorCount                    (err),
    .lastFAcycle                   (falast),
    .dbgRxState                    (dbg)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && strobe) begin
      if (sb.size() == 0) begin
        ntests++;
        nfail++;
        $error("FAIL unexpected_strobe: observed code %0d, none expected",
               code);
      end else begin
        e = sb.pop_front();
        chk("strobe_code", 32'(code), 32'(e.code));
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic [31:0] hdr(input int i);
    logic [4:0] ix = 5'(i);
    return {16'hA5BE, 1'b1, 5'd12, 1'b0, 4'd2, ix};
  endfunction

  function automatic logic [31:0] wx(input int i);
    logic [4:0] ix = 5'(i);
    return {16'hCAFE, 11'd0, ix};
  endfunction

  function automatic logic [31:0] wy(input int i);
    logic [4:0] ix = 5'(i);
    return {16'hBEEF, 11'd0, ix};
  endfunction

  function automatic logic [31:0] ws(input int i, input int f);
    logic [4:0]  ix = 5'(i);
    logic [14:0] fc = 15'(f);
    return {1'b0, fc, 5'd0, 6'd0, ix};
  endfunction

  task automatic beat(input logic [31:0] d, input logic l);
    @(negedge clk);
    tdata  = d;
    tvalid = 1'b1;
    tlast  = l;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic fa_pulse();
    @(negedge clk);
    fa = 1'b1;
    @(posedge clk);
    #1;
    fa = 1'b0;
  endtask

  task automatic pkt(input int i, input int f);
    beat(hdr(i), 1'b0);
    beat(wx(i), 1'b0);
    beat(wy(i), 1'b0);
    beat(ws(i, f), 1'b1);
  endtask

  // Strobe is due on the cycle right after the last S beat.
  task automatic run(input int first, input int n,
                     input int f, input int c);
    for (int k = first; k < first + n; k++) pkt(k, f);
    if (c >= 0) sb.push_back('{cyc, 2'(c)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    tvalid = 1'b0;
    fa     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_tready", 32'(tready), 0);
    chk("rst_strobe", 32'(strobe), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_good", good, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_falast", 32'(falast), 0);
    chk("rst_state", 32'(dbg), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_up", 32'(tready), 1);

    // Full clean session, then one surplus packet
    fa_pulse();
    run(0, 16, 7, 0);
    settle("good_drain");
    chk("good_cnt", good, 16);
    chk("good_err", 32'(err), 0);
    chk("good_falast", 32'(falast), 7);
    pkt(16, 7);
    settle("surplus_drain");
    chk("surplus_err", 32'(err), 1);
    chk("surplus_good", good, 16);

    // Content error in X of packet 5
    do_reset();
    fa_pulse();
    run(0, 5, 7, -1);
    beat(hdr(5), 1'b0);
    beat(32'hCAFE0006, 1'b0);
    beat(wy(5), 1'b0);
    beat(ws(5, 7), 1'b1);
    run(6, 10, 7, 2);
    settle("content_drain");
    chk("content_good", good, 15);
    chk("content_err", 32'(err), 1);

    // tlast on Y of packet 3, then retransmit
    do_reset();
    fa_pulse();
    run(0, 3, 7, -1);
    beat(hdr(3), 1'b0);
    beat(wx(3), 1'b0);
    beat(wy(3), 1'b1);
    chk("ylast_state", 32'(dbg), 0);
    chk("ylast_err", 32'(err), 1);
    run(3, 13, 7, 1);
    settle("ylast_drain");
    chk("ylast_good", good, 16);
    chk("ylast_err_end", 32'(err), 1);

    // Missing tlast on S, resync through junk
    do_reset();
    fa_pulse();
    beat(hdr(0), 1'b0);
    beat(wx(0), 1'b0);
    beat(wy(0), 1'b0);
    beat(ws(0, 7), 1'b0);
    chk("resync_state", 32'(dbg), 4);
    beat(32'h1234_5678, 1'b0);
    chk("resync_hold", 32'(dbg), 4);
    beat(32'h9ABC_DEF0, 1'b1);
    chk("resync_exit", 32'(dbg), 0);
    run(0, 16, 7, 1);
    settle("resync_drain");
    chk("resync_good", good, 16);
    chk("resync_err", 32'(err), 1);

    // Short session then a full one
    do_reset();
    fa_pulse();
    run(0, 9, 20, -1);
    fa_pulse();
    sb.push_back('{cyc, 2'd3});
    run(0, 16, 21, 0);
    settle("short_drain");
    chk("short_good", good, 25);
    chk("short_err", 32'(err), 0);

    // FA counters 7 then 9
    do_reset();
    fa_pulse();
    run(0, 16, 7, 0);
    fa_pulse();
    run(0, 16, 9, 32'(FA_CODE));
    settle("facyc_drain");
    chk("facyc_good", good, FA_GOOD);
    chk("facyc_err", 32'(err), FA_ERR);
    chk("facyc_last", 32'(falast), 9);

    // Reset asserted mid-packet at the Y beat
    do_reset();
    fa_pulse();
    run(0, 2, 30, -1);
    beat(hdr(2), 1'b0);
    beat(wx(2), 1'b0);
    @(negedge clk);
    tdata  = wy(2);
    tvalid = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("midrst_tready", 32'(tready), 0);
    chk("midrst_good", good, 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_falast", 32'(falast), 0);
    chk("midrst_state", 32'(dbg), 0);
    @(negedge clk);
    tvalid = 1'b0;
    rst_n  = 1'b1;
    fa_pulse();
    run(0, 16, 30, 0);
    settle("midrst_drain");
    chk("midrst_good_end", good, 16);
    chk("midrst_err_end", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
